vga_pixel_fetch: RTL and testbench

- Pixel-fetch stage directly downstream of the VGA timing generator.
- Consumes the generator's pixel coordinates and its sync/blank signals.
- Reads a double-buffered 320×240 RGB332 framebuffer from synchronous RAM, upscaling 2× to 640×480, and drives the DAC colour outputs with sync/blank delayed to match.
- Also owns the frame-synchronous buffer-swap handshake with the processor side.

---
 rtl/vga_pixel_fetch.sv | 176 +++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch behind the VGA timing generator: 2x-upscaled RGB332 framebuffer reads, colour expansion, frame-synced buffer swap.
// Define VGA_BORDER_EN to force a white one-pixel border around the visible area.
module vga_pixel_fetch #(
    localparam int unsigned AW = 18
) (
    input  logic          vgaclk,
    input  logic          rst_n,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          blank_b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          base_sel,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          sync_b
);

    localparam int unsigned HACTIVE = 640;
    localparam int unsigned VACTIVE = 480;
    localparam int unsigned FB_W    = HACTIVE / 2;
    localparam int unsigned FB_H    = VACTIVE / 2;
    localparam int unsigned FB_SIZE = FB_W * FB_H;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    swap_state_e   state_q, state_d;
    logic          base_sel_q, base_sel_d;
    logic          swap_ack_q, swap_ack_d;
    logic          vs_prev_q;
    logic          vs_fall_c;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW-1:0] row_c;
    logic [AW-1:0] base_c;
    logic          unused_lsb_c;

    logic [1:0]    blank_p_q;
    logic [1:0]    hs_p_q;
    logic [1:0]    vs_p_q;

    logic [7:0]    vga_r_q, vga_r_d;
    logic [7:0]    vga_g_q, vga_g_d;
    logic [7:0]    vga_b_q, vga_b_d;
    logic          hsync_q, vsync_q, blank_b_q, sync_b_q;

`ifdef VGA_BORDER_EN
    logic          border_c;
    logic [1:0]    border_p_q;

    assign border_c = blank_b_in && (x == 10'(0) || x == 10'(HACTIVE - 1) ||
                                     y == 10'(0) || y == 10'(VACTIVE - 1));
`endif

    assign vs_fall_c    = !vsync_in && vs_prev_q;
    assign unused_lsb_c = ^{x[0], y[0]};

    // Swap handshake: a request waits for the next vsync falling edge
    always_comb begin
        state_d    = state_q;
        base_sel_d = base_sel_q;
        swap_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) state_d = PENDING;
            end
            PENDING: begin
                if (vs_fall_c) begin
                    state_d    = IDLE;
                    base_sel_d = ~base_sel_q;
                    swap_ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // S1: row*320 built from two shifts
    always_comb begin
        row_c      = AW'(y[9:1]);
        base_c     = base_sel_q ? AW'(FB_SIZE) : '0;
        mem_addr_d = '0;
        if (blank_b_in) begin
            mem_addr_d = base_c + (row_c << 8) + (row_c << 6) + AW'(x[9:1]);
        end
    end

    // S3: RGB332 bit-replicated to 8 bits per channel
    always_comb begin
        vga_r_d = '0;
        vga_g_d = '0;
        vga_b_d = '0;
        if (blank_p_q[1]) begin
            vga_r_d = {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
            vga_g_d = {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]};
            vga_b_d = {4{mem_rdata[1:0]}};
`ifdef VGA_BORDER_EN
            if (border_p_q[1]) begin
                vga_r_d = 8'hFF;
                vga_g_d = 8'hFF;
                vga_b_d = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_sel_q <= 1'b0;
            swap_ack_q <= 1'b0;
            vs_prev_q  <= 1'b1;
            mem_addr_q <= '0;
            blank_p_q  <= '0;
            hs_p_q     <= '1;
            vs_p_q     <= '1;
            vga_r_q    <= '0;
            vga_g_q    <= '0;
            vga_b_q    <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_b_q  <= 1'b0;
            sync_b_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            base_sel_q <= base_sel_d;
            swap_ack_q <= swap_ack_d;
            vs_prev_q  <= vsync_in;
            mem_addr_q <= mem_addr_d;
            blank_p_q  <= {blank_p_q[0], blank_b_in};
            hs_p_q     <= {hs_p_q[0], hsync_in};
            vs_p_q     <= {vs_p_q[0], vsync_in};
            vga_r_q    <= vga_r_d;
            vga_g_q    <= vga_g_d;
            vga_b_q    <= vga_b_d;
            hsync_q    <= hs_p_q[1];
            vsync_q    <= vs_p_q[1];
            blank_b_q  <= blank_p_q[1];
            sync_b_q   <= hs_p_q[1] & vs_p_q[1];
        end
    end

`ifdef VGA_BORDER_EN
    // Border flag rides alongside the sync pipeline
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            border_p_q <= '0;
        end else begin
            border_p_q <= {border_p_q[0], border_c};
        end
    end
`endif

    assign mem_addr = mem_addr_q;
    assign swap_ack = swap_ack_q;
    assign base_sel = base_sel_q;
    assign vga_r    = vga_r_q;
    assign vga_g    = vga_g_q;
    assign vga_b    = vga_b_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign blank_b  = blank_b_q;
    assign sync_b   = sync_b_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: pixel path latency/addressing/colour, swap handshake and reset.
module tb_vga_pixel_fetch;

    localparam int unsigned FB_SIZE = 76800;
    localparam int unsigned NTAB    = 12;

    logic        vgaclk;
    logic        rst_n;
    logic [9:0]  x, y;
    logic        blank_b_in, hsync_in, vsync_in;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        swap_req, swap_ack, base_sel;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, blank_b, sync_b;

    int vectors     = 0;
    int miscompares = 0;
    int pcnt        = 0;
    int exp_base    = 0;

    logic [7:0] ram [0:2*FB_SIZE-1];

    typedef struct {
        int          due;
        int          id;
        logic [17:0] addr;
    } aexp_t;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] r, g, b;
        logic       hs, vs, bl, sb;
    } oexp_t;

    aexp_t aq[$];
    oexp_t oq[$];

    int   tab_x  [NTAB] = '{0, 1, 2, 639, 1, 639, 0, 320, 700, 750, 800, 799};
    int   tab_y  [NTAB] = '{0, 0, 3, 479, 1, 0, 479, 240, 10, 10, 490, 524};
    logic tab_bl [NTAB] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic tab_hs [NTAB] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic tab_vs [NTAB] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    vga_pixel_fetch dut (
        .vgaclk     (vgaclk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .blank_b_in (blank_b_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .base_sel   (base_sel),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_b    (blank_b),
        .sync_b     (sync_b)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) pcnt <= pcnt + 1;

    // Synchronous RAM: data for the sampled address one cycle later
    always @(posedge vgaclk) mem_rdata <= ram[mem_addr];

    task automatic drive_idle();
        x          = 10'd0;
        y          = 10'd0;
        blank_b_in = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        swap_req   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        blank_b_in = 1'b1;
        x = 10'd100;
        y = 10'd50;
        repeat (3) @(negedge vgaclk);
        vectors++;
        if ({mem_addr, base_sel, swap_ack, vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b}
            !== {18'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values got addr=%0d sel=%b ack=%b rgb=%h%h%h hs=%b vs=%b bl=%b sb=%b want all idle",
                     mem_addr, base_sel, swap_ack, vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b);
        end
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_pixel_path(input int nrand);
        int          n, px, py;
        logic        pb, phs, pvs;
        logic [17:0] ea;
        logic [7:0]  d;
        logic [2:0]  c3;
        logic [1:0]  c2;
        aexp_t       a;
        oexp_t       o;
        n = NTAB + nrand;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge vgaclk);
            if (aq.size() > 0 && aq[0].due == pcnt) begin
                a = aq.pop_front();
                vectors++;
                if (mem_addr !== a.addr) begin
                    miscompares++;
                    $display("FAIL addr pix%0d got %0d want %0d", a.id, mem_addr, a.addr);
                end
            end
            if (oq.size() > 0 && oq[0].due == pcnt) begin
                o = oq.pop_front();
                vectors++;
                if ({vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b} !==
                    {o.r, o.g, o.b, o.hs, o.vs, o.bl, o.sb}) begin
                    miscompares++;
                    $display("FAIL out pix%0d got rgb=%h/%h/%h hs=%b vs=%b bl=%b sb=%b want rgb=%h/%h/%h hs=%b vs=%b bl=%b sb=%b",
                             o.id, vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b,
                             o.r, o.g, o.b, o.hs, o.vs, o.bl, o.sb);
                end
            end
            if (i < n) begin
                if (i < int'(NTAB)) begin
                    px = tab_x[i]; py = tab_y[i]; pb = tab_bl[i]; phs = tab_hs[i]; pvs = tab_vs[i];
                end else begin
                    pb  = ($urandom_range(0, 3) != 0);
                    px  = pb ? int'($urandom_range(0, 639)) : int'($urandom_range(640, 799));
                    py  = int'($urandom_range(0, 479));
                    phs = 1'($urandom_range(0, 1));
                    pvs = 1'($urandom_range(0, 1));
                end
                x = 10'(px); y = 10'(py); blank_b_in = pb; hsync_in = phs; vsync_in = pvs;
                ea = pb ? 18'(exp_base * int'(FB_SIZE) + (py / 2) * 320 + px / 2) : 18'd0;
                d  = ram[ea];
                o.r = 8'd0; o.g = 8'd0; o.b = 8'd0;
                if (pb) begin
                    c3 = d[7:5]; o.r = {c3, c3, c3[2:1]};
                    c3 = d[4:2]; o.g = {c3, c3, c3[2:1]};
                    c2 = d[1:0]; o.b = {c2, c2, c2, c2};
`ifdef VGA_BORDER_EN
                    if (px == 0 || px == 639 || py == 0 || py == 479) begin
                        o.r = 8'hFF; o.g = 8'hFF; o.b = 8'hFF;
                    end
`endif
                end
                o.hs = phs; o.vs = pvs; o.bl = pb; o.sb = phs & pvs;
                o.id = i; o.due = pcnt + 3;
                a.id = i; a.due = pcnt + 1; a.addr = ea;
                aq.push_back(a);
                oq.push_back(o);
            end else begin
                drive_idle();
            end
        end
        vectors++;
        if (aq.size() != 0 || oq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d/%0d left want 0/0", aq.size(), oq.size());
            aq.delete();
            oq.delete();
        end
    endtask

    // req at 2 (2nd at 6 ignored), req coincident with a fall at 20, req at 40; falls at 10,20,30,45
    task automatic test_swap();
        int   base0;
        logic eack, ebase;
        base0 = exp_base;
        drive_idle();
        for (int c = 0; c < 50; c++) begin
            @(negedge vgaclk);
            eack  = (c == 11 || c == 31 || c == 46);
            ebase = 1'(base0) ^ (c >= 11) ^ (c >= 31) ^ (c >= 46);
            vectors++;
            if ({swap_ack, base_sel} !== {eack, ebase}) begin
                miscompares++;
                $display("FAIL swap c%0d got ack=%b sel=%b want ack=%b sel=%b", c, swap_ack, base_sel, eack, ebase);
            end
            swap_req = (c == 2 || c == 6 || c == 20 || c == 40);
            vsync_in = !((c >= 10 && c < 14) || (c >= 20 && c < 24) || (c >= 30 && c < 33) || (c >= 45 && c < 48));
        end
        drive_idle();
        exp_base = base0 ^ 1;
    endtask

    task automatic test_reset_pending();
        @(negedge vgaclk);
        swap_req = 1'b1;
        x = 10'd10; y = 10'd20; blank_b_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
        @(negedge vgaclk);
        swap_req = 1'b0;
        repeat (4) @(negedge vgaclk);
        #1 rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if ({mem_addr, base_sel, swap_ack, vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b}
                !== {18'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_mid%0d got addr=%0d sel=%b ack=%b rgb=%h%h%h hs=%b vs=%b bl=%b sb=%b want all idle",
                         k, mem_addr, base_sel, swap_ack, vga_r, vga_g, vga_b, hsync, vsync, blank_b, sync_b);
            end
            repeat (2) @(negedge vgaclk);
        end
        drive_idle();
        rst_n = 1'b1;
        exp_base = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge vgaclk);
            vectors++;
            if ({swap_ack, base_sel} !== 2'b00) begin
                miscompares++;
                $display("FAIL no_swap_after_reset c%0d got ack=%b sel=%b want ack=0 sel=0", c, swap_ack, base_sel);
            end
            vsync_in = !(c >= 2 && c < 5);
        end
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < int'(2 * FB_SIZE); i++) ram[i] = 8'(i * 37 + (i >> 9));
        ram[0] = 8'hE3;
        test_reset();
        test_pixel_path(60);
        test_swap();
        ram[0] = 8'hFF;
        test_pixel_path(60);
        test_reset_pending();
        test_pixel_path(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
